// File: rtl/ber_test_ctrl.sv
// BER test sequencer: bit-rate strobe, warm-up, measurement phase and
// error-injection timing for the pattern generator, plus progress counters.
module ber_test_ctrl #(
  parameter int DIV_W  = 16,
  parameter int CNT_W  = 32,
  parameter int WARMUP = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             STOP,
  input  logic [DIV_W-1:0] RATE_DIV,
  input  logic [CNT_W-1:0] LEN,
  input  logic             SINGLE_REQ,
  input  logic             CONT_ERR,
  output logic             PG_EN,
  output logic             PG_SINGLE,
  output logic             PG_ERROR,
  output logic             BUSY,
  output logic             DONE,
  output logic [CNT_W-1:0] BIT_CNT,
  output logic [CNT_W-1:0] ERR_CNT
);

  localparam int WU_W = $clog2(WARMUP + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARM  = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [DIV_W-1:0] rate_q, rate_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [WU_W-1:0]  warm_q, warm_d;
  logic             pend_q, pend_d;
  logic             pg_en_q, pg_en_d;
  logic             pg_single_q, pg_single_d;
  logic             pg_error_q, pg_error_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] err_q, err_d;

  logic active, in_run, run_strobe, next_active, next_run, issue, div_wrap;
  logic [CNT_W-1:0] bit_inc;

  // Next-state, divider, counters and injection decisions
  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    len_d       = len_q;
    div_d       = div_q;
    warm_d      = warm_q;
    bit_d       = bit_q;
    err_d       = err_q;

    active      = (state_q == S_ARM) || (state_q == S_RUN);
    in_run      = (state_q == S_RUN);
    run_strobe  = pg_en_q && in_run;
    div_wrap    = (div_q == rate_q);
    bit_inc     = (bit_q == '1) ? bit_q : bit_q + 1'b1;

    // Divider free-runs only while a test is active.
    if (active) div_d = div_wrap ? '0 : div_q + 1'b1;

    if (state_q == S_ARM && pg_en_q) warm_d = warm_q + 1'b1;
    if (run_strobe) bit_d = bit_inc;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (START && !STOP) begin
          state_d = S_ARM;
          rate_d  = RATE_DIV;
          len_d   = LEN;
          div_d   = '0;
          warm_d  = '0;
          bit_d   = '0;
          err_d   = '0;
        end
      end
      S_ARM: begin
        if (STOP) state_d = S_IDLE;
        else if (pg_en_q && warm_q == WU_W'(WARMUP - 1)) state_d = S_RUN;
      end
      S_RUN: begin
        if (STOP) state_d = S_IDLE;
        else if (run_strobe && len_q != '0 && bit_inc == len_q) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    next_active = (state_d == S_ARM) || (state_d == S_RUN);
    next_run    = (state_d == S_RUN);

    // Strobe only if we are still active next cycle, so DONE/IDLE stay silent.
    pg_en_d     = active && div_wrap && next_active;

    // Single pulse lands the cycle after a strobe; dropped if RUN is ending.
    issue       = run_strobe && pend_q && next_run;
    pg_single_d = issue;
    pend_d      = in_run && next_run && ((pend_q && !issue) || SINGLE_REQ);

    pg_error_d  = CONT_ERR && next_run;

    // One error count per bit even if single and continuous coincide.
    if (run_strobe && (pg_error_q || issue) && err_q != '1) err_d = err_q + 1'b1;

    busy_d      = next_active;
    done_d      = (state_d == S_DONE);
  end

  // State and output registers
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      rate_q      <= '0;
      len_q       <= '0;
      div_q       <= '0;
      warm_q      <= '0;
      pend_q      <= 1'b0;
      pg_en_q     <= 1'b0;
      pg_single_q <= 1'b0;
      pg_error_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bit_q       <= '0;
      err_q       <= '0;
    end else begin
      state_q     <= state_d;
      rate_q      <= rate_d;
      len_q       <= len_d;
      div_q       <= div_d;
      warm_q      <= warm_d;
      pend_q      <= pend_d;
      pg_en_q     <= pg_en_d;
      pg_single_q <= pg_single_d;
      pg_error_q  <= pg_error_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bit_q       <= bit_d;
      err_q       <= err_d;
    end
  end

  assign PG_EN     = pg_en_q;
  assign PG_SINGLE = pg_single_q;
  assign PG_ERROR  = pg_error_q;
  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign BIT_CNT   = bit_q;
  assign ERR_CNT   = err_q;

endmodule

// File: tb/tb_ber_test_ctrl.sv
// Scoreboard bench for ber_test_ctrl: expectations queued at stimulus time,
// popped and compared when the corresponding DUT behaviour is observed.
module tb_ber_test_ctrl;
  localparam int DIV_W  = 16;
  localparam int CNT_W  = 32;
  localparam int WARMUP = 32;

  logic             CLK = 1'b0;
  logic             RST = 1'b0;
  logic             START = 1'b0, STOP = 1'b0, SINGLE_REQ = 1'b0, CONT_ERR = 1'b0;
  logic [DIV_W-1:0] RATE_DIV = '0;
  logic [CNT_W-1:0] LEN = '0;
  logic             PG_EN, PG_SINGLE, PG_ERROR, BUSY, DONE;
  logic [CNT_W-1:0] BIT_CNT, ERR_CNT;

  ber_test_ctrl #(.DIV_W(DIV_W), .CNT_W(CNT_W), .WARMUP(WARMUP)) dut (
    .CLK(CLK), .RST(RST), .START(START), .STOP(STOP), .RATE_DIV(RATE_DIV),
    .LEN(LEN), .SINGLE_REQ(SINGLE_REQ), .CONT_ERR(CONT_ERR), .PG_EN(PG_EN),
    .PG_SINGLE(PG_SINGLE), .PG_ERROR(PG_ERROR), .BUSY(BUSY), .DONE(DONE),
    .BIT_CNT(BIT_CNT), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct { string tag; logic [31:0] val; } exp_t;
  exp_t sb_q[$];
  int n_cmp = 0, n_bad = 0;

  // monitor state
  int cyc, strobes, last_st, first_st, period, gap_bad;
  int singles, single_bad, last_single, arm_err, run_st, run_prev;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_chk(input logic [31:0] obs);
    exp_t e;
    if (sb_q.size() == 0) begin
      chk("sb_empty", 32'(sb_q.size()), 32'd1);
      return;
    end
    e = sb_q.pop_front();
    chk(e.tag, obs, e.val);
  endtask

  task automatic mon_clr(input int per);
    cyc = 0; strobes = 0; last_st = 0; first_st = 0; period = per; gap_bad = 0;
    singles = 0; single_bad = 0; last_single = 0; arm_err = 0; run_st = 0; run_prev = 0;
  endtask

  // Advance one cycle and sample 1ns after the edge.
  task automatic step();
    @(posedge CLK); #1;
    cyc++;
    run_prev = run_st;
    if (PG_SINGLE) begin
      singles++; last_single = cyc;
      if (cyc != last_st + 1) single_bad++;
    end
    if (PG_EN) begin
      if (strobes > 0 && cyc - last_st != period) gap_bad++;
      strobes++;
      if (strobes == 1) first_st = cyc;
      last_st = cyc;
      if (strobes > WARMUP) run_st++;
    end
    if (BUSY && (PG_ERROR || PG_SINGLE) &&
        (strobes < WARMUP || (strobes == WARMUP && cyc == last_st))) arm_err++;
  endtask

  task automatic start_run(input int rate, input int len);
    RATE_DIV = DIV_W'(rate); LEN = CNT_W'(len);
    START = 1'b1;
    @(posedge CLK); #1;
    START = 1'b0;
    mon_clr(rate + 1);
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget && !DONE; i++) step();
  endtask

  initial begin
    int s0, c0;
    mon_clr(1);
    #1 RST = 1'b1;
    // reset state
    sb_push("rst_flags", 0); sb_push("rst_bit", 0); sb_push("rst_err", 0);
    #20;
    sb_chk(32'({PG_EN, PG_SINGLE, PG_ERROR, BUSY, DONE}));
    sb_chk(BIT_CNT); sb_chk(ERR_CNT);
    RST = 1'b0;

    // basic run: rate 3, len 10
    sb_push("basic_busy", 1); sb_push("basic_first", 4); sb_push("basic_done", 1);
    sb_push("basic_bit", 10); sb_push("basic_err", 0); sb_push("basic_strobes", WARMUP + 10);
    sb_push("basic_gap", 0); sb_push("basic_busy_end", 0); sb_push("basic_silent", 0);
    start_run(3, 10);
    step();
    sb_chk(32'(BUSY));
    wait_done(400);
    sb_chk(32'(first_st)); sb_chk(32'(DONE)); sb_chk(BIT_CNT); sb_chk(ERR_CNT);
    sb_chk(32'(strobes)); sb_chk(32'(gap_bad)); sb_chk(32'(BUSY));
    s0 = strobes;
    repeat (12) step();
    sb_chk(32'(strobes - s0));

    // full rate, open-ended, stop after 100 RUN strobes
    sb_push("full_first", 1); sb_push("full_gap", 0); sb_push("full_flags", 0);
    sb_push("full_bit", 100);
    start_run(0, 0);
    for (int i = 0; i < 400; i++) begin
      step();
      if (strobes == WARMUP + 100) break;
    end
    STOP = 1'b1; step(); STOP = 1'b0;
    sb_chk(32'(first_st)); sb_chk(32'(gap_bad));
    sb_chk(32'({PG_EN, PG_SINGLE, PG_ERROR, BUSY, DONE})); sb_chk(BIT_CNT);

    // single injection: request in ARM ignored, three merged requests in RUN
    sb_push("sgl_arm_pulses", 0); sb_push("sgl_arm_err", 0); sb_push("sgl_arm_flags", 0);
    sb_push("sgl_pulses", 1); sb_push("sgl_placement", 0); sb_push("sgl_offset", 9);
    sb_push("sgl_err", 1);
    start_run(7, 0);
    for (int i = 0; i < 600 && strobes < WARMUP + 2; i++) begin
      step();
      SINGLE_REQ = (cyc == 10);
    end
    SINGLE_REQ = 1'b0;
    sb_chk(32'(singles)); sb_chk(ERR_CNT); sb_chk(32'(arm_err));
    c0 = cyc;
    for (int i = 0; i < 100 && strobes < WARMUP + 5; i++) begin
      step();
      SINGLE_REQ = (cyc - c0 == 1) || (cyc - c0 == 3) || (cyc - c0 == 5);
    end
    SINGLE_REQ = 1'b0;
    sb_chk(32'(singles)); sb_chk(32'(single_bad)); sb_chk(32'(last_single - c0));
    sb_chk(ERR_CNT);
    STOP = 1'b1; step(); STOP = 1'b0;

    // continuous injection held high across ARM, RUN and DONE
    sb_push("cont_arm", 0); sb_push("cont_done", 1); sb_push("cont_bit", 20);
    sb_push("cont_err", 20); sb_push("cont_done_perr", 0);
    CONT_ERR = 1'b1;
    start_run(1, 20);
    wait_done(300);
    sb_chk(32'(arm_err)); sb_chk(32'(DONE)); sb_chk(BIT_CNT); sb_chk(ERR_CNT);
    repeat (3) step();
    sb_chk(32'(PG_ERROR));
    CONT_ERR = 1'b0;

    // START from DONE clears counters; PG_ERROR lag; START ignored in RUN
    sb_push("redo_bit", 0); sb_push("redo_err", 0); sb_push("redo_busy", 1);
    sb_push("perr_lag0", 0); sb_push("perr_lag1", 1);
    start_run(1, 0);
    sb_chk(BIT_CNT); sb_chk(ERR_CNT); sb_chk(32'(BUSY));
    for (int i = 0; i < 200 && strobes < WARMUP + 10; i++) step();
    sb_chk(32'(PG_ERROR));
    CONT_ERR = 1'b1;
    step();
    sb_chk(32'(PG_ERROR));
    CONT_ERR = 1'b0;
    START = 1'b1; step(); START = 1'b0;
    step(); step();
    sb_push("ign_start_busy", 1); sb_push("ign_start_bit", 32'(run_prev));
    sb_chk(32'(BUSY)); sb_chk(BIT_CNT);
    STOP = 1'b1; step(); STOP = 1'b0;
    repeat (3) step();
    sb_push("stop_flags", 0); sb_push("stop_hold", 32'(run_st));
    sb_chk(32'({PG_EN, PG_SINGLE, PG_ERROR, BUSY, DONE})); sb_chk(BIT_CNT);
    // START and STOP together from IDLE
    sb_push("ss_busy", 0); sb_push("ss_strobes", 0);
    s0 = strobes;
    START = 1'b1; STOP = 1'b1; step(); START = 1'b0; STOP = 1'b0;
    repeat (6) step();
    sb_chk(32'(BUSY)); sb_chk(32'(strobes - s0));

    // asynchronous reset mid-run, then a clean run
    sb_push("arst_flags", 0); sb_push("arst_bit", 0); sb_push("arst_err", 0);
    CONT_ERR = 1'b1;
    start_run(3, 0);
    for (int i = 0; i < 400 && strobes < WARMUP + 8; i++) step();
    #3 RST = 1'b1;
    #1;
    sb_chk(32'({PG_EN, PG_SINGLE, PG_ERROR, BUSY, DONE})); sb_chk(BIT_CNT); sb_chk(ERR_CNT);
    #2 RST = 1'b0;
    CONT_ERR = 1'b0;
    step();
    sb_push("post_first", 4); sb_push("post_done", 1); sb_push("post_bit", 5);
    sb_push("post_err", 0); sb_push("post_strobes", WARMUP + 5);
    start_run(3, 5);
    wait_done(300);
    sb_chk(32'(first_st)); sb_chk(32'(DONE)); sb_chk(BIT_CNT); sb_chk(ERR_CNT);
    sb_chk(32'(strobes));

    chk("sb_leftover", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
